// File: rtl/serial_slice_alu.sv
// Bit-serial ALU: processes SLICE_W bits per clock, LSB slice first.
// Logic ops, ADD, SUB and signed SLT all pass through the same slice path;
// SUB/SLT invert B per slice and seed the carry with 1.
module serial_slice_alu #(
    parameter int WIDTH   = 32,
    parameter int SLICE_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       sel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             overflow,
    output logic             zero
);
    localparam int N     = WIDTH / SLICE_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_NOR  = 3'd1;
    localparam logic [2:0] OP_OR   = 3'd2;
    localparam logic [2:0] OP_XOR  = 3'd3;
    localparam logic [2:0] OP_NAND = 3'd4;
    localparam logic [2:0] OP_ADD  = 3'd5;
    localparam logic [2:0] OP_SUB  = 3'd6;
    localparam logic [2:0] OP_SLT  = 3'd7;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               carry;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   acc;
    logic [2:0]         op;

    logic [SLICE_W-1:0] a_s;
    logic [SLICE_W-1:0] b_s;
    logic [SLICE_W-1:0] b_eff;
    logic [SLICE_W-1:0] slice_res;
    logic [SLICE_W:0]   sum;
    logic [WIDTH-1:0]   acc_next;
    logic [WIDTH-1:0]   res_next;
    logic               is_sub;
    logic               arith;
    logic               c_msb_in;
    logic               ovf;
    logic               last;

    // Per-slice result: bitwise ops use the raw operands, arithmetic uses the adder.
    function automatic logic [SLICE_W-1:0] slice_op(input logic [2:0] o,
                                                    input logic [SLICE_W-1:0] x,
                                                    input logic [SLICE_W-1:0] y,
                                                    input logic [SLICE_W-1:0] s);
        case (o)
            OP_AND:  slice_op = x & y;
            OP_NOR:  slice_op = ~(x | y);
            OP_OR:   slice_op = x | y;
            OP_XOR:  slice_op = x ^ y;
            OP_NAND: slice_op = ~(x & y);
            default: slice_op = s;
        endcase
    endfunction

    // SLT collapses the full difference to a single signed less-than bit.
    function automatic logic [WIDTH-1:0] final_result(input logic [2:0] o,
                                                      input logic [WIDTH-1:0] raw,
                                                      input logic v);
        if (o == OP_SLT)
            final_result = {{(WIDTH-1){1'b0}}, raw[WIDTH-1] ^ v};
        else
            final_result = raw;
    endfunction

    // Slice adder, carry bookkeeping and next accumulator value.
    always_comb begin
        a_s       = a_sh[SLICE_W-1:0];
        b_s       = b_sh[SLICE_W-1:0];
        is_sub    = (op == OP_SUB) || (op == OP_SLT);
        arith     = (op == OP_ADD) || (op == OP_SUB);
        b_eff     = is_sub ? ~b_s : b_s;
        sum       = {1'b0, a_s} + {1'b0, b_eff} + {{SLICE_W{1'b0}}, carry};
        // Sum bit = a ^ b ^ carry_in, so the carry into the slice MSB falls out directly.
        c_msb_in  = sum[SLICE_W-1] ^ a_s[SLICE_W-1] ^ b_eff[SLICE_W-1];
        ovf       = sum[SLICE_W] ^ c_msb_in;
        slice_res = slice_op(op, a_s, b_s, sum[SLICE_W-1:0]);
        acc_next  = (acc >> SLICE_W) | (WIDTH'(slice_res) << (WIDTH - SLICE_W));
        res_next  = final_result(op, acc_next, ovf);
        last      = (cnt == LAST);
    end

    // Control FSM, slice counter, running carry and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            cnt      <= '0;
            carry    <= 1'b0;
            result   <= '0;
            carryout <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        cnt   <= '0;
                        carry <= (sel == OP_SUB) || (sel == OP_SLT);
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    carry <= sum[SLICE_W];
                    if (last) begin
                        cnt      <= '0;
                        state    <= DONE;
                        done     <= 1'b1;
                        result   <= res_next;
                        carryout <= arith & sum[SLICE_W];
                        overflow <= arith & ovf;
                        zero     <= (res_next == '0);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Operand shift registers and accumulator; every slice is rewritten per op, so no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            a_sh <= a;
            b_sh <= b;
            op   <= sel;
        end else if (state == RUN) begin
            a_sh <= a_sh >> SLICE_W;
            b_sh <= b_sh >> SLICE_W;
            acc  <= acc_next;
        end
    end
endmodule

// File: tb/tb_serial_slice_alu.sv
// Scoreboard bench for serial_slice_alu: the driver pushes expected results
// from an arithmetic reference model, the monitor pops them on each done pulse.
module tb_serial_slice_alu;
    localparam int W  = 32;
    localparam int SW = 4;
    localparam int N  = W / SW;

    logic          clk = 1'b0;
    logic          reset;
    logic          start = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic [2:0]    sel = '0;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic          carryout;
    logic          overflow;
    logic          zero;

    typedef struct packed {
        logic [31:0] res;
        logic        co;
        logic        ov;
        logic        z;
    } exp_t;

    exp_t q[$];
    exp_t hold = {32'h0, 1'b0, 1'b0, 1'b1};
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   pushed = 0;
    int   dones = 0;

    serial_slice_alu #(.WIDTH(W), .SLICE_W(SW)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .sel(sel),
        .busy(busy), .done(done), .result(result), .carryout(carryout),
        .overflow(overflow), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on whole operands.
    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic [2:0] s);
        exp_t e;
        logic [32:0] t;
        e = '0;
        t = '0;
        case (s)
            3'd0: e.res = x & y;
            3'd1: e.res = ~(x | y);
            3'd2: e.res = x | y;
            3'd3: e.res = x ^ y;
            3'd4: e.res = ~(x & y);
            3'd5: begin
                t = {1'b0, x} + {1'b0, y};
                e.res = t[31:0];
                e.co = t[32];
                e.ov = (x[31] == y[31]) && (e.res[31] != x[31]);
            end
            3'd6: begin
                e.res = x - y;
                e.co = (x >= y);
                e.ov = (x[31] != y[31]) && (e.res[31] != x[31]);
            end
            default: e.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
        endcase
        e.z = (e.res == 32'd0);
        return e;
    endfunction

    // Monitor: compare on done, otherwise check the outputs hold their last value.
    always @(negedge clk) begin
        if (reset) begin
            hold = {32'h0, 1'b0, 1'b0, 1'b1};
        end else if (done) begin
            dones++;
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: result=%0h with no pending op", result);
            end else begin
                mon_e = q.pop_front();
                chk("result", result, mon_e.res);
                chk("carryout", carryout, mon_e.co);
                chk("overflow", overflow, mon_e.ov);
                chk("zero", zero, mon_e.z);
                hold = mon_e;
            end
        end else begin
            chk("hold", {result, carryout, overflow, zero}, hold);
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 50 && busy; i++) @(negedge clk);
        chk("idle_reached", busy, 1'b0);
    endtask

    task automatic do_op(input logic [31:0] ta, input logic [31:0] tb, input logic [2:0] ts);
        int lat;
        wait_idle();
        @(negedge clk);
        a = ta; b = tb; sel = ts; start = 1'b1;
        q.push_back(model(ta, tb, ts));
        pushed++;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom; b = $urandom; sel = 3'($urandom_range(0, 7));
        chk("busy_after_start", busy, 1'b1);
        lat = -1;
        for (int i = 1; i <= N + 4; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        chk("latency", lat, N);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_result"}, result, 32'h0);
        chk({tag, "_carryout"}, carryout, 1'b0);
        chk({tag, "_overflow"}, overflow, 1'b0);
        chk({tag, "_zero"}, zero, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int d0;
        logic [31:0] ra, rb;
        reset = 1'b1;
        #1;
        check_reset_vals("reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Directed corner cases
        do_op(32'h7FFFFFFF, 32'h00000001, 3'd5);
        do_op(32'd5, 32'd7, 3'd6);
        do_op(32'd7, 32'd7, 3'd6);
        do_op(32'hFFFFFFFF, 32'd1, 3'd7);
        do_op(32'd1, 32'hFFFFFFFF, 3'd7);
        do_op(32'hFFFF0000, 32'hFF00FF00, 3'd4);
        do_op(32'hFFFF0000, 32'hFF00FF00, 3'd1);
        do_op(32'h80000000, 32'h80000000, 3'd5);
        do_op(32'h80000000, 32'd1, 3'd6);

        // Starts while busy are ignored, including during DONE
        wait_idle();
        d0 = dones;
        @(negedge clk);
        a = 32'd1; b = 32'd1; sel = 3'd5; start = 1'b1;
        q.push_back(model(32'd1, 32'd1, 3'd5));
        pushed++;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            a = 32'd9; b = 32'd9; sel = 3'd5;
            start = (k == 3 || k == 8 || k == 9);
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        repeat (N + 4) @(posedge clk);
        #1;
        chk("single_done", dones - d0, 1);

        // Asynchronous reset mid-operation aborts it
        wait_idle();
        @(negedge clk);
        a = 32'd3; b = 32'd4; sel = 3'd5; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        d0 = dones;
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("abort");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (N + 4) @(posedge clk);
        #1;
        chk("abort_no_done", dones - d0, 0);
        do_op(32'd3, 32'd4, 3'd5);

        // Random operations
        repeat (40) begin
            ra = $urandom;
            rb = ($urandom_range(0, 4) == 0) ? ra : $urandom;
            do_op(ra, rb, 3'($urandom_range(0, 7)));
        end

        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", q.size(), 0);
        chk("done_count", dones, pushed);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
